flash_sequencer: RTL and testbench
==================================

Name: flash_sequencer

Overview:
- Upstream timing stage for the colour-flash display. Each round, it walks the stored colour sequence from index 0 to round_len-1.
- For each element it drives the read index (check_round) and the flash strobe (flash_clk) that the flash display uses to latch segment[check_round] into its lamps.
- It inserts a blank gap between elements and reports completion so the game FSM can hand control to player input.

Parameters:
- ON_TICKS, 8, number of tick pulses each element stays lit (1..255)
- OFF_TICKS, 4, number of tick pulses of blank gap after each element (1..255)
- MIN_ON_TICKS, 2, lower bound on lit duration when SPEEDUP_EN is defined (1..ON_TICKS)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to play the current sequence
- abort  input  1  cancel playback immediately
- tick  input  1  timebase enable pulse, one clk wide
- round_len  input  6  number of elements to play; 0..32, values >32 clamp to 32
- check_round  output  5  sequence index presented to the flash display
- flash_clk  output  1  registered strobe; high while the element is lit, and its rising edge latches the colour
- blank  output  1  high during gaps/idle; flash display clears its lamps
- busy  output  1  high from the cycle after start until return to IDLE
- done  output  1  one-cycle pulse after the last gap completes

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; check_round=0, flash_clk=0, blank=1, busy=0, done=0; counters=0.
- Registers: all outputs registered on posedge clk; no combinational input-to-output path.
- States: IDLE, SETUP, ON, OFF.
- IDLE:
  - On start=1 with round_len!=0, latch len=min(round_len,32), set check_round=0, go to SETUP; busy=1 next cycle.
  - On start=1 with round_len=0: no flash; done=1 for exactly one cycle next cycle; stay IDLE.
- SETUP (exactly 1 clk):
  - Holds check_round stable one full cycle before the flash_clk rising edge.
  - Loads tick counter with ON_TICKS and goes to ON.
- ON:
  - flash_clk=1, blank=0.
  - Counter decrements on each tick. When counter==1 and tick=1: load OFF_TICKS, go to OFF, flash_clk=0 and blank=1 next cycle.
- OFF:
  - flash_clk=0, blank=1.
  - When counter==1 and tick=1:
    - if check_round==len-1: go to IDLE, done=1 for one cycle, busy=0;
    - else check_round+=1, go to SETUP.
- Latency: start at edge t -> SETUP at t+1 -> flash_clk rises at t+2.
  - With tick tied high, each element occupies 1+ON_TICKS+OFF_TICKS cycles.
- tick=0 freezes counters; states other than SETUP hold indefinitely.
- start while busy: ignored; no restart, no state change.
- abort=1 (any non-IDLE state): next cycle IDLE, flash_clk=0, blank=1, busy=0, check_round=0, done not asserted.
  - abort has priority over start and tick in the same cycle. abort in IDLE has no effect, but also suppresses a simultaneous start.
- Index width: check_round 5 bits; len=32 plays indices 0..31 with no wrap past 31.
- round_len changes during playback have no effect; the value latched at start is used.
- done and start in the same cycle (IDLE re-entry): start is honoured on the following IDLE cycle only, i.e. a start coincident with the done pulse is ignored.

Optional Feature:
- Macro: FLASH_SEQUENCER_SPEEDUP_EN.
- Defined: lit duration per element = max(ON_TICKS - (len>>2), MIN_ON_TICKS).
  - Computed once at start, in 9-bit signed arithmetic, before clamping. OFF duration is unchanged.
- Undefined: lit duration is always ON_TICKS; MIN_ON_TICKS is unused.

Test Plan:
- Reset mid-ON (round_len=5, ON_TICKS=8, tick=1) -> assert reset_n=0 for 1 cycle -> immediately flash_clk=0, blank=1, busy=0, check_round=0; no done.
- tick=1, round_len=3, defaults -> flash_clk rises at t+2, t+15, t+28, each high 8 cycles; check_round 0,1,2 each stable ≥1 cycle before its rise; done pulses once at t+40; busy high t+1..t+39.
- round_len=0, start -> done=1 exactly at t+1, flash_clk never rises, busy stays 0.
- round_len=40 -> exactly 32 flash_clk rises, last with check_round=31, then done; no wrap to 0.
- tick every 3rd cycle, round_len=1 -> flash_clk high for 24 cycles, gap 12 cycles, then done; start pulsed mid-ON is ignored; abort during OFF of a round_len=4 run -> IDLE next cycle, no done.
- FLASH_SEQUENCER_SPEEDUP_EN defined, ON_TICKS=8, MIN_ON_TICKS=2, round_len=12 -> lit 5 ticks per element; round_len=32 -> lit 2 ticks (clamped).

Source files
------------

// File: rtl/flash_sequencer.sv
// flash_sequencer: walks the stored colour sequence, driving check_round and the flash_clk strobe with blank gaps.
// Latency: start sampled at edge t -> SETUP at t+1 -> flash_clk high from t+2. Each element takes 1+ON+OFF ticked cycles.
// Flow: tick is a timebase enable, and tick=0 freezes the counters. start is ignored while busy. abort returns to IDLE.
// Optional feature: define FLASH_SEQUENCER_SPEEDUP_EN to shorten the lit time as the round grows.
module flash_sequencer #(
  parameter int ON_TICKS     = 8,
  parameter int OFF_TICKS    = 4,
  parameter int MIN_ON_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       tick,
  input  logic [5:0] round_len,
  output logic [4:0] check_round,
  output logic       flash_clk,
  output logic       blank,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ON    = 2'd2,
    S_OFF   = 2'd3
  } state_t;

  localparam logic [7:0] LP_OFF = 8'(OFF_TICKS);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [5:0] r_len;
  logic [4:0] r_check_round;
  logic       r_flash_clk;
  logic       r_blank;
  logic       r_busy;
  logic       r_done;

  logic [5:0] w_len_clamped;
  logic [5:0] w_len_m1;
  logic       w_last;
  logic [7:0] w_on_new;
  logic [7:0] w_on_load;

  assign w_len_clamped = (round_len > 6'd32) ? 6'd32 : round_len;
  assign w_len_m1      = r_len - 6'd1;
  assign w_last        = ({1'b0, r_check_round} == w_len_m1);

`ifdef FLASH_SEQUENCER_SPEEDUP_EN
  localparam logic [7:0] LP_ON  = 8'(ON_TICKS);
  localparam logic [7:0] LP_MIN = 8'(MIN_ON_TICKS);

  logic [5:0]        w_len_q4;
  logic signed [8:0] w_on_diff;
  logic [7:0]        r_on_ticks;

  // Lit duration shrinks by one tick per four elements, floored at MIN_ON_TICKS.
  // The subtraction is signed so that a long round is not wrapped before the floor is applied.
  assign w_len_q4  = w_len_clamped >> 2;
  assign w_on_diff = $signed({1'b0, LP_ON}) - $signed({3'b000, w_len_q4});
  assign w_on_new  = (w_on_diff < $signed({1'b0, LP_MIN})) ? LP_MIN : w_on_diff[7:0];
  assign w_on_load = r_on_ticks;

  // Latch the lit duration once, when playback starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_on_ticks <= LP_ON;
    end else if (r_state == S_IDLE && start && !abort && !r_done) begin
      r_on_ticks <= w_on_new;
    end
  end
`else
  // MIN_ON_TICKS is only a floor. For legal parameters this gives exactly ON_TICKS.
  localparam int         LP_ON_FLOOR = (ON_TICKS > MIN_ON_TICKS) ? ON_TICKS : MIN_ON_TICKS;
  localparam logic [7:0] LP_ON       = 8'(LP_ON_FLOOR);

  assign w_on_new  = LP_ON;
  assign w_on_load = w_on_new;
`endif

  // Sequencer FSM. All outputs are registered together with the state transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_len         <= 6'd0;
      r_check_round <= 5'd0;
      r_flash_clk   <= 1'b0;
      r_blank       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_check_round <= 5'd0;
      r_flash_clk   <= 1'b0;
      r_blank       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done      <= 1'b0;
          r_flash_clk <= 1'b0;
          r_blank     <= 1'b1;
          r_busy      <= 1'b0;
          // A start that coincides with the done pulse, or with abort, is dropped.
          if (start && !abort && !r_done) begin
            if (round_len == 6'd0) begin
              r_done <= 1'b1;
            end else begin
              r_len         <= w_len_clamped;
              r_check_round <= 5'd0;
              r_busy        <= 1'b1;
              r_state       <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          // check_round has been stable for one full cycle, so the strobe can rise now.
          r_cnt       <= w_on_load;
          r_flash_clk <= 1'b1;
          r_blank     <= 1'b0;
          r_state     <= S_ON;
        end
        S_ON: begin
          if (tick) begin
            if (r_cnt == 8'd1) begin
              r_cnt       <= LP_OFF;
              r_flash_clk <= 1'b0;
              r_blank     <= 1'b1;
              r_state     <= S_OFF;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (r_cnt == 8'd1) begin
              r_cnt <= 8'd0;
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_check_round <= r_check_round + 5'd1;
                r_state       <= S_SETUP;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign check_round = r_check_round;
  assign flash_clk   = r_flash_clk;
  assign blank       = r_blank;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench for flash_sequencer: reset, timing of whole rounds, clamping, tick gating, abort, ignored starts.
// Expected timings are worked out by hand from the element period 1+ON+OFF.
module tb_flash_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       tick;
  logic [5:0] round_len;
  logic [4:0] check_round;
  logic       flash_clk;
  logic       blank;
  logic       busy;
  logic       done;

  flash_sequencer #(
    .ON_TICKS     (8),
    .OFF_TICKS    (4),
    .MIN_ON_TICKS (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .tick        (tick),
    .round_len   (round_len),
    .check_round (check_round),
    .flash_clk   (flash_clk),
    .blank       (blank),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Observations collected over one playback.
  int n_rise, n_hi, n_done, done_k, n_busy, busy_first, busy_last, fall_k, n_stable, n_badblank;
  int rise_k  [40];
  int rise_cr [40];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_on(input int len);
    int l;
    int d;
    l = (len > 32) ? 32 : len;
    d = 8;
`ifdef FLASH_SEQUENCER_SPEEDUP_EN
    d = 8 - (l >> 2);
    if (d < 2) d = 2;
`endif
    return d;
  endfunction

  // Start a round in cycle 0, then record outputs for cycles 1..ncyc.
  // tper=1 keeps tick high. Otherwise tick fires when k%tper==1.
  task automatic play(input logic [5:0] len, input int ncyc, input int tper,
                      input int xstart_k, input int abort_k);
    logic pf;
    logic [4:0] pc;
    n_rise = 0; n_hi = 0; n_done = 0; done_k = -1; n_busy = 0;
    busy_first = -1; busy_last = -1; fall_k = -1; n_stable = 0; n_badblank = 0;
    pf = flash_clk;
    pc = check_round;
    round_len = len;
    start = 1'b1;
    abort = (abort_k == 0);
    tick = (tper == 1);
    for (int k = 1; k <= ncyc; k++) begin
      step();
      if (flash_clk && !pf) begin
        if (n_rise < 40) begin
          rise_k[n_rise]  = k;
          rise_cr[n_rise] = int'(check_round);
        end
        if (check_round == pc) n_stable++;
        n_rise++;
      end
      if (!flash_clk && pf && fall_k < 0) fall_k = k;
      if (flash_clk) n_hi++;
      if (blank == flash_clk) n_badblank++;
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (busy) begin
        n_busy++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      pf = flash_clk;
      pc = check_round;
      start = (k == xstart_k);
      abort = (k == abort_k);
      tick  = (tper == 1) ? 1'b1 : ((k % tper) == 1);
    end
    start = 1'b0;
    abort = 1'b0;
    tick  = 1'b0;
  endtask

  // Full round with tick tied high. Timings follow from the period 1+on+OFF.
  task automatic check_play(input int len);
    int l, on, per;
    l   = (len > 32) ? 32 : len;
    on  = exp_on(len);
    per = 1 + on + 4;
    play(6'(len), 1 + l * per + 8, 1, -1, -1);
    chk("rise_count",  n_rise, l);
    chk("rise0_cycle", rise_k[0], 2);
    chk("riseL_cycle", rise_k[l-1], 2 + (l - 1) * per);
    chk("first_idx",   rise_cr[0], 0);
    chk("mid_idx",     rise_cr[l/2], l/2);
    chk("last_idx",    rise_cr[l-1], l - 1);
    chk("idx_stable",  n_stable, l);
    chk("lit_cycles",  n_hi, l * on);
    chk("blank_inv",   n_badblank, 0);
    chk("done_count",  n_done, 1);
    chk("done_cycle",  done_k, 1 + l * per);
    chk("busy_first",  busy_first, 1);
    chk("busy_last",   busy_last, l * per);
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    tick      = 1'b0;
    round_len = 6'd0;
    repeat (3) step();
    chk("rst_idx",   int'(check_round), 0);
    chk("rst_flash", int'(flash_clk), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    reset_n = 1'b1;
    step();

    // Three elements, including the interior index.
    check_play(3);

    // An empty round gives an immediate done and no flash.
    play(6'd0, 6, 1, -1, -1);
    chk("len0_done",  n_done, 1);
    chk("len0_dk",    done_k, 1);
    chk("len0_rise",  n_rise, 0);
    chk("len0_busy",  n_busy, 0);
    step();

    // Twelve elements. With the speedup feature the lit time is 5 ticks.
    check_play(12);

    // Oversized length clamps to 32 elements, ending on index 31.
    check_play(40);

    // tick every 3rd cycle. A start pulsed mid-ON must not restart the round.
    play(6'd1, 45, 3, 10, -1);
    chk("slow_rise",  n_rise, 1);
    chk("slow_r0",    rise_k[0], 2);
    chk("slow_fall",  fall_k, 2 + 3 * exp_on(1));
    chk("slow_lit",   n_hi, 3 * exp_on(1));
    chk("slow_done",  done_k, 2 + 3 * exp_on(1) + 12);
    chk("slow_dcnt",  n_done, 1);
    step();

    // Abort during the first gap of a 4-element round.
    play(6'd4, 30, 1, -1, 11);
    chk("abort_done", n_done, 0);
    chk("abort_rise", n_rise, 1);
    chk("abort_busy", busy_last, 11);
    chk("abort_idx",  int'(check_round), 0);
    chk("abort_blank", int'(blank), 1);
    chk("abort_flash", int'(flash_clk), 0);

    // abort in IDLE suppresses a simultaneous start.
    play(6'd2, 10, 1, -1, 0);
    chk("idle_abort_busy", n_busy, 0);
    chk("idle_abort_rise", n_rise, 0);
    chk("idle_abort_done", n_done, 0);

    // A start coincident with the done pulse is dropped.
    play(6'd1, 30, 1, 1 + (1 + exp_on(1) + 4), -1);
    chk("dstart_rise", n_rise, 1);
    chk("dstart_busy", n_busy, 1 + exp_on(1) + 4);
    chk("dstart_done", n_done, 1);

    // Asynchronous reset in the middle of a lit element.
    round_len = 6'd5;
    tick  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_flash", int'(flash_clk), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flash", int'(flash_clk), 0);
    chk("arst_blank", int'(blank), 1);
    chk("arst_busy",  int'(busy), 0);
    chk("arst_idx",   int'(check_round), 0);
    chk("arst_done",  int'(done), 0);
    step();
    reset_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("post_rst_done", n_done, 0);
    chk("post_rst_busy", n_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
